ibex_data_sram_adapter: RTL and testbench

Bridges the load/store unit's data-bus request/grant/rvalid interface to a single-port, fixed-latency, arbitrated data SRAM. It sits directly downstream of the load/store unit and consumes its `data_req`/`data_addr`/`data_we`/`data_be`/`data_wdata` outputs. It returns in-order `data_rvalid`/`data_rdata`/`data_err` responses. Out-of-range accesses never reach the SRAM; they are answered with an error response.

---
 rtl/ibex_data_sram_adapter.sv | 134 +++++++++++++
 tb/tb_ibex_data_sram_adapter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_data_sram_adapter.sv
// Bridges the LSU data-bus req/gnt/rvalid protocol to a fixed-latency, arbitrated single-port SRAM.
// Optional macro IBEX_DSRAM_RDATA_REG_EN registers the response path (one extra cycle of load latency).
module ibex_data_sram_adapter #(
    parameter logic [31:0] AddrBase       = 32'h0001_0000,
    parameter int unsigned MemDepthWords  = 1024,
    parameter int unsigned SramLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             data_req_i,
    output logic                             data_gnt_o,
    output logic                             data_rvalid_o,
    output logic                             data_err_o,
    input  logic [31:0]                      data_addr_i,
    input  logic                             data_we_i,
    input  logic [3:0]                       data_be_i,
    input  logic [31:0]                      data_wdata_i,
    output logic [31:0]                      data_rdata_o,
    output logic                             sram_req_o,
    input  logic                             sram_gnt_i,
    output logic                             sram_we_o,
    output logic [$clog2(MemDepthWords)-1:0] sram_addr_o,
    output logic [31:0]                      sram_wmask_o,
    output logic [31:0]                      sram_wdata_o,
    input  logic [31:0]                      sram_rdata_i,
    output logic                             busy_o,
    output logic [15:0]                      stall_cnt_o
);

    localparam int unsigned AW    = $clog2(MemDepthWords);
    localparam int unsigned CW    = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] WinLo = {1'b0, AddrBase};
    localparam logic [32:0] WinHi = WinLo + 33'(4 * MemDepthWords);

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } token_t;

    token_t        pipe_q [SramLatency];
    token_t        token_in;
    token_t        token_out;
    logic [CW-1:0] cnt_q;
    logic [15:0]   stall_q;
    logic          in_range;
    logic          can_issue;
    logic          resp_valid;
    logic [31:0]   offset;
    logic          unused_offset;

    // Request path: range decode and outstanding cap, fully combinational.
    assign in_range  = ({1'b0, data_addr_i} >= WinLo) && ({1'b0, data_addr_i} < WinHi);
    assign offset    = data_addr_i - AddrBase;
    assign can_issue = !rst_i && (cnt_q < CW'(MaxOutstanding));

    assign sram_req_o    = data_req_i && in_range && can_issue;
    assign data_gnt_o    = data_req_i && can_issue && (in_range ? sram_gnt_i : 1'b1);
    assign sram_addr_o   = offset[2 +: AW];
    assign sram_we_o     = data_we_i;
    assign sram_wdata_o  = data_wdata_i;
    assign sram_wmask_o  = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                            {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    assign unused_offset = ^{offset[1:0], offset[31:AW+2]};

    assign token_in  = '{valid: data_gnt_o, err: !in_range, we: data_we_i};
    assign token_out = pipe_q[SramLatency-1];

    // Tracking pipeline mirrors the SRAM latency so error and good responses stay in order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SramLatency); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= token_in;
            for (int i = 1; i < int'(SramLatency); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

`ifdef IBEX_DSRAM_RDATA_REG_EN
    logic        rvalid_q;
    logic        rerr_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= token_out.valid;
            rerr_q   <= token_out.valid && token_out.err;
            rdata_q  <= (token_out.valid && !token_out.err && !token_out.we) ? sram_rdata_i : '0;
        end
    end

    assign resp_valid   = rvalid_q;
    assign data_err_o   = rerr_q;
    assign data_rdata_o = rdata_q;
`else
    // Reset drops a token that would otherwise exit during the reset cycle.
    assign resp_valid   = token_out.valid && !rst_i;
    assign data_err_o   = resp_valid && token_out.err;
    assign data_rdata_o = (resp_valid && !token_out.err && !token_out.we) ? sram_rdata_i : '0;
`endif

    assign data_rvalid_o = resp_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (data_gnt_o && !resp_valid) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (!data_gnt_o && resp_valid) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (data_req_i && !data_gnt_o && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign busy_o      = (cnt_q != '0);
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ibex_data_sram_adapter.sv
// Self-checking bench for ibex_data_sram_adapter: directed vector table, corner sequences and
// randomized traffic against a transaction-level model (response queue + reference memory).
module tb_ibex_data_sram_adapter;

    localparam logic [31:0] Base  = 32'h0001_0000;
    localparam int unsigned Depth = 16;
    localparam int unsigned Lat   = 2;
    localparam int unsigned MaxO  = 2;
    localparam int unsigned AW    = $clog2(Depth);
`ifdef IBEX_DSRAM_RDATA_REG_EN
    localparam int unsigned RLat  = Lat + 1;
    localparam bit          RegEn = 1'b1;
`else
    localparam int unsigned RLat  = Lat;
    localparam bit          RegEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          data_req_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic          data_err_o;
    logic [31:0]   data_addr_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_wdata_i;
    logic [31:0]   data_rdata_o;
    logic          sram_req_o;
    logic          sram_gnt_i;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wmask_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i;
    logic          busy_o;
    logic [15:0]   stall_cnt_o;

    always #5 clk = ~clk;

    ibex_data_sram_adapter #(
        .AddrBase      (Base),
        .MemDepthWords (Depth),
        .SramLatency   (Lat),
        .MaxOutstanding(MaxO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_err_o   (data_err_o),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .sram_req_o   (sram_req_o),
        .sram_gnt_i   (sram_gnt_i),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wmask_o (sram_wmask_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .busy_o       (busy_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    // Environment SRAM: fixed-latency read line, garbage on the bus when no read is returning.
    logic [31:0] sram_mem [Depth];
    logic [31:0] rd_line  [Lat];
    assign sram_rdata_i = rd_line[Lat-1];

    always @(posedge clk) begin
        for (int i = int'(Lat) - 1; i > 0; i--) rd_line[i] <= rd_line[i-1];
        if (sram_req_o && sram_gnt_i && !sram_we_o) rd_line[0] <= sram_mem[sram_addr_o];
        else                                        rd_line[0] <= $urandom;
        if (sram_req_o && sram_gnt_i && sram_we_o)
            sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_wmask_o) |
                                     (sram_wdata_o & sram_wmask_o);
    end

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        x_req;
        logic [31:0] x_saddr;
        logic [31:0] x_mask;
        logic        x_err;
        logic [31:0] x_rdata;
    } vec_t;

    resp_t       exp_q[$];
    logic [31:0] ref_mem [Depth];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned stall_ref = 0;
    int unsigned resp_seen = 0;
    logic        g_gnt = 1'b0;
    logic        g_inr = 1'b0;
    bit          log_en = 1'b0;
    logic        gnt_log[$];

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare this cycle's DUT outputs with the model; called mid-cycle on the falling edge.
    task automatic check_cycle();
        logic [63:0] a;
        logic        inr, room, eg, er, ev;
        a    = {32'h0, data_addr_i};
        inr  = (a >= 64'(Base)) && (a < 64'(Base) + 64'(4 * Depth));
        room = exp_q.size() < int'(MaxO);
        eg   = !rst_i && data_req_i && room && (inr ? sram_gnt_i : 1'b1);
        er   = !rst_i && data_req_i && room && inr;
        chk("data_gnt", 32'(data_gnt_o), 32'(eg));
        chk("sram_req", 32'(sram_req_o), 32'(er));
        if (er) begin
            chk("sram_addr",  32'(sram_addr_o), (data_addr_i - Base) / 4);
            chk("sram_we",    32'(sram_we_o), 32'(data_we_i));
            chk("sram_wmask", sram_wmask_o, be_mask(data_be_i));
            chk("sram_wdata", sram_wdata_o, data_wdata_i);
        end
        ev = !rst_i && (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (!RegEn || !rst_i) chk("rvalid", 32'(data_rvalid_o), 32'(ev));
        if (ev) begin
            chk("rerr",  32'(data_err_o), 32'(exp_q[0].err));
            chk("rdata", data_rdata_o, exp_q[0].data);
        end
        chk("busy", 32'(busy_o), 32'(exp_q.size() != 0));
        chk("stall_cnt", 32'(stall_cnt_o), stall_ref);
        if (data_rvalid_o) resp_seen++;
        if (log_en) gnt_log.push_back(data_gnt_o);
        g_gnt = eg;
        g_inr = inr;
    endtask

    // Advance the model across the rising edge.
    task automatic update();
        resp_t       r;
        int unsigned idx;
        logic [31:0] m;
        if (rst_i) begin
            exp_q.delete();
            stall_ref = 0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
            if (data_req_i && !g_gnt && stall_ref < 32'hFFFF) stall_ref++;
            if (g_gnt) begin
                r.due  = cyc + RLat;
                r.err  = !g_inr;
                r.data = 32'h0;
                if (g_inr) begin
                    idx = (data_addr_i - Base) >> 2;
                    if (data_we_i) begin
                        m = be_mask(data_be_i);
                        ref_mem[idx] = (ref_mem[idx] & ~m) | (data_wdata_i & m);
                    end else begin
                        r.data = ref_mem[idx];
                    end
                end
                exp_q.push_back(r);
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        data_req_i   = req;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wd;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update();
        #1;
    endtask

    // Hold a request until the model says it is granted (bounded).
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        int   n = 0;
        logic done = 1'b0;
        drive(1'b1, addr, we, be, wd);
        while (!done && n < 20) begin
            @(negedge clk);
            check_cycle();
            done = g_gnt;
            @(posedge clk);
            update();
            #1;
            n++;
        end
        chk("grant_within_bound", 32'(done), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, Base, 1'b0, 4'hF, 32'h0);
        while (exp_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_within_bound", 32'(exp_q.size()), 32'h0);
        step();
    endtask

    vec_t        tv [11];
    int unsigned st0;
    int unsigned rs0;
    int unsigned sel;

    initial begin
        tv[0]  = '{32'h0001_0010, 1'b1, 4'hF,    32'hDEAD_BEEF, 1'b1, 32'd4,  32'hFFFF_FFFF, 1'b0, 32'h0};
        tv[1]  = '{32'h0001_0010, 1'b0, 4'hF,    32'h0,         1'b1, 32'd4,  32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF};
        tv[2]  = '{32'h0001_0004, 1'b1, 4'b0110, 32'h1122_3344, 1'b1, 32'd1,  32'h00FF_FF00, 1'b0, 32'h0};
        tv[3]  = '{32'h0001_0004, 1'b0, 4'hF,    32'h0,         1'b1, 32'd1,  32'hFFFF_FFFF, 1'b0, 32'hA522_3301};
        tv[4]  = '{32'h0000_FFFC, 1'b0, 4'hF,    32'h0,         1'b0, 32'd0,  32'h0,         1'b1, 32'h0};
        tv[5]  = '{32'h0001_0008, 1'b1, 4'h0,    32'hFFFF_FFFF, 1'b1, 32'd2,  32'h0000_0000, 1'b0, 32'h0};
        tv[6]  = '{32'h0001_0008, 1'b0, 4'hF,    32'h0,         1'b1, 32'd2,  32'hFFFF_FFFF, 1'b0, 32'hA5A5_0002};
        tv[7]  = '{32'h0001_003C, 1'b0, 4'hF,    32'h0,         1'b1, 32'd15, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_000F};
        tv[8]  = '{32'h0001_0040, 1'b0, 4'hF,    32'h0,         1'b0, 32'd0,  32'h0,         1'b1, 32'h0};
        tv[9]  = '{32'h0001_0040, 1'b1, 4'hF,    32'h1234_5678, 1'b0, 32'd0,  32'h0,         1'b1, 32'h0};
        tv[10] = '{32'hFFFF_FFFC, 1'b0, 4'hF,    32'h0,         1'b0, 32'd0,  32'h0,         1'b1, 32'h0};

        rst_i      = 1'b1;
        sram_gnt_i = 1'b1;
        drive(1'b0, Base, 1'b0, 4'hF, 32'h0);
        repeat (3) step();
        rst_i = 1'b0;

        // Reset state.
        @(negedge clk);
        check_cycle();
        chk("rst_gnt",    32'(data_gnt_o),    32'h0);
        chk("rst_rvalid", 32'(data_rvalid_o), 32'h0);
        chk("rst_err",    32'(data_err_o),    32'h0);
        chk("rst_rdata",  data_rdata_o,       32'h0);
        chk("rst_sreq",   32'(sram_req_o),    32'h0);
        chk("rst_busy",   32'(busy_o),        32'h0);
        chk("rst_stall",  32'(stall_cnt_o),   32'h0);
        @(posedge clk);
        update();
        #1;

        // Known memory image: word i = A5A5_00ii.
        for (int i = 0; i < int'(Depth); i++)
            issue(Base + 32'(4 * i), 1'b1, 4'hF, 32'hA5A5_0000 | 32'(i));
        drain();

        // Directed vectors, one isolated access each.
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, tv[k].addr, tv[k].we, tv[k].be, tv[k].wdata);
            @(negedge clk);
            check_cycle();
            chk("tv_gnt",  32'(data_gnt_o), 32'h1);
            chk("tv_sreq", 32'(sram_req_o), 32'(tv[k].x_req));
            if (tv[k].x_req) begin
                chk("tv_saddr", 32'(sram_addr_o), tv[k].x_saddr);
                chk("tv_wmask", sram_wmask_o, tv[k].x_mask);
                chk("tv_swe",   32'(sram_we_o), 32'(tv[k].we));
            end
            @(posedge clk);
            update();
            #1;
            drive(1'b0, Base, 1'b0, 4'hF, 32'h0);
            for (int j = 1; j <= int'(RLat); j++) begin
                @(negedge clk);
                check_cycle();
                if (j == int'(RLat)) begin
                    chk("tv_rvalid", 32'(data_rvalid_o), 32'h1);
                    chk("tv_err",    32'(data_err_o), 32'(tv[k].x_err));
                    chk("tv_rdata",  data_rdata_o, tv[k].x_rdata);
                end else begin
                    chk("tv_early_rvalid", 32'(data_rvalid_o), 32'h0);
                end
                @(posedge clk);
                update();
                #1;
            end
        end
        drain();

        // Back-to-back loads hitting the outstanding cap.
        gnt_log.delete();
        log_en = 1'b1;
        st0 = stall_ref;
        rs0 = resp_seen;
        for (int i = 0; i < 4; i++) issue(Base + 32'(4 * (8 + i)), 1'b0, 4'hF, 32'h0);
        drain();
        log_en = 1'b0;
        chk("b2b_gnt_c0", 32'(gnt_log[0]), 32'h1);
        chk("b2b_gnt_c1", 32'(gnt_log[1]), 32'h1);
        chk("b2b_gnt_c2", 32'(gnt_log[2]), 32'h0);
        chk("b2b_stall",  32'(stall_cnt_o), st0 + (RLat - 1));
        chk("b2b_resps",  resp_seen - rs0, 32'd4);

        // Arbiter loss for three cycles, straight after reset.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rs0 = resp_seen;
        sram_gnt_i = 1'b0;
        drive(1'b1, Base + 32'h14, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle();
            chk("arb_no_gnt",   32'(data_gnt_o), 32'h0);
            chk("arb_req_held", 32'(sram_req_o), 32'h1);
            @(posedge clk);
            update();
            #1;
        end
        sram_gnt_i = 1'b1;
        @(negedge clk);
        check_cycle();
        chk("arb_gnt4",  32'(data_gnt_o), 32'h1);
        chk("arb_stall", 32'(stall_cnt_o), 32'd3);
        @(posedge clk);
        update();
        #1;
        drain();
        chk("arb_one_resp", resp_seen - rs0, 32'd1);

        // Reset one cycle after a grant drops the response.
        drive(1'b1, Base + 32'h18, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check_cycle();
        chk("rmf_gnt", 32'(data_gnt_o), 32'h1);
        @(posedge clk);
        update();
        #1;
        drive(1'b0, Base, 1'b0, 4'hF, 32'h0);
        rs0 = resp_seen;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        check_cycle();
        chk("rmf_busy", 32'(busy_o), 32'h0);
        @(posedge clk);
        update();
        #1;
        repeat (RLat + 2) step();
        chk("rmf_no_resp", resp_seen - rs0, 32'd0);

        // Randomized traffic with arbiter loss and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            if (!data_req_i && $urandom_range(9) < 7) begin
                sel = $urandom_range(9);
                if (sel < 7)       data_addr_i = Base + 32'(4 * $urandom_range(Depth - 1));
                else if (sel == 7) data_addr_i = Base - 32'(4 * $urandom_range(3, 1));
                else if (sel == 8) data_addr_i = Base + 32'(4 * Depth) + 32'(4 * $urandom_range(2));
                else               data_addr_i = $urandom & 32'hFFFF_FFFC;
                data_req_i   = 1'b1;
                data_we_i    = 1'($urandom_range(1));
                data_be_i    = 4'($urandom);
                data_wdata_i = $urandom;
            end
            sram_gnt_i = ($urandom_range(3) != 0);
            rst_i      = ($urandom_range(399) == 0);
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            update();
            #1;
            if (g_gnt) data_req_i = 1'b0;
        end
        rst_i = 1'b0;
        sram_gnt_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
